// File: rtl/insn_sequencer_if.sv
// Instruction-memory fetch channel: request handshake plus response.
// The sequencer is the master; the memory is the slave.
interface insn_sequencer_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/insn_sequencer.sv
// Multi-cycle fetch/exec/writeback control FSM with a 32-entry regfile.
// Drives a combinational execution unit; halts on SYSTEM or bad opcodes.
module insn_sequencer #(
  parameter int          XLEN     = 32,
  parameter int unsigned RESET_PC = 0,
  parameter int          RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  insn_sequencer_if.master    imem,
  output logic [6:0]          ex_opcode,
  output logic [2:0]          ex_funct3,
  output logic [6:0]          ex_funct7,
  output logic [19:0]         ex_imm,
  output logic [XLEN-1:0]     ex_rs1,
  output logic [XLEN-1:0]     ex_rs2,
  input  logic                ex_rd_we,
  input  logic [XLEN-1:0]     ex_rd,
  output logic [XLEN-1:0]     pc,
  output logic [RETIRE_W-1:0] retired,
  output logic                halted,
  output logic                illegal,
  input  logic [4:0]          dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  state_t          state;
  logic [31:0]     ir;
  logic [XLEN-1:0] rf [32];
  logic            wb_we;
  logic [XLEN-1:0] wb_data;
  logic            is_alu;
  logic            is_sys;

  // Request is a pure decode of the registered state, gated so it
  // stays low for the whole time reset is asserted.
  assign imem.imem_req_valid = rst_n && (state == S_FETCH);
  assign imem.imem_addr      = pc;

  assign ex_opcode = ir[6:0];
  assign ex_funct3 = ir[14:12];
  assign ex_funct7 = ir[31:25];
  assign ex_imm    = ir[31:12];
  assign ex_rs1    = rf[ir[19:15]];
  assign ex_rs2    = rf[ir[24:20]];

  // x0 is never written, so it reads back as zero everywhere.
  assign dbg_data = rf[dbg_addr];

  assign is_alu = (ir[6:0] == OP_LUI) || (ir[6:0] == OP_ALU);
  assign is_sys = (ir[6:0] == OP_SYS);

  // Sequencer FSM together with PC, counters, IR and regfile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      pc      <= XLEN'(RESET_PC);
      retired <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
      ir      <= '0;
      wb_we   <= 1'b0;
      wb_data <= '0;
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else begin
      unique case (state)
        S_FETCH: begin
          if (imem.imem_req_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_rsp_valid) begin
            ir    <= imem.imem_rsp_data;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          unique case (1'b1)
            is_alu: begin
              wb_we   <= ex_rd_we;
              wb_data <= ex_rd;
              state   <= S_WB;
            end
            is_sys: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: begin
              halted  <= 1'b1;
              illegal <= 1'b1;
              state   <= S_HALT;
            end
          endcase
        end
        S_WB: begin
          if (wb_we && (ir[11:7] != 5'd0)) begin
            rf[ir[11:7]] <= wb_data;
          end
          pc      <= pc + XLEN'(4);
          retired <= retired + RETIRE_W'(1);
          state   <= S_FETCH;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule
